// File: rtl/btn_conditioner_if.sv
// Button bundle between the board pins and the fan controller.
// The master drives the raw pin levels; the slave (the conditioner) returns
// the cleaned levels and the event pulses.
interface btn_conditioner_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_lvl;
  logic [N_BTN-1:0] btn_pedge;
  logic [N_BTN-1:0] btn_nedge;
  logic [N_BTN-1:0] long_p;
  logic [N_BTN-1:0] rep_p;

  modport master (
    output btn_raw,
    input  btn_lvl, btn_pedge, btn_nedge, long_p, rep_p
  );

  modport slave (
    input  btn_raw,
    output btn_lvl, btn_pedge, btn_nedge, long_p, rep_p
  );
endinterface

// File: rtl/btn_conditioner.sv
// Push-button front end: synchronise, debounce on a shared ms tick, then
// derive press/release edges, a long-press pulse and auto-repeat pulses.
// One btn_chan instance per button; the prescaler and synchroniser are shared.

module btn_chan #(
  parameter int DEB_TICKS  = 10,
  parameter int LONG_TICKS = 1000,
  parameter int REP_TICKS  = 200,
  parameter bit REP_EN     = 1'b1
) (
  input  logic clk,
  input  logic reset_p,
  input  logic tick_i,
  input  logic sync_i,
  output logic lvl_o,
  output logic pedge_o,
  output logic nedge_o,
  output logic long_o,
  output logic rep_o
);
  localparam int DW   = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam int HMAX = (LONG_TICKS > REP_TICKS) ? LONG_TICKS : REP_TICKS;
  localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} st_t;

  logic [DW-1:0] deb_q, deb_d;
  logic          lvl_q, lvl_d;
  logic          pedge_q, pedge_d, nedge_q, nedge_d;
  logic          flip;
  st_t           st_q, st_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d, rep_q, rep_d;

  // Debounce: count ticks while the synced pin disagrees with the level;
  // any agreement restarts the window.
  always_comb begin
    deb_d = deb_q;
    lvl_d = lvl_q;
    flip  = 1'b0;
    if (sync_i == lvl_q) begin
      deb_d = '0;
    end else if (tick_i) begin
      if (deb_q == DW'(DEB_TICKS - 1)) begin
        flip  = 1'b1;
        deb_d = '0;
        lvl_d = sync_i;
      end else begin
        deb_d = deb_q + DW'(1);
      end
    end
    pedge_d = flip & sync_i;
    nedge_d = flip & ~sync_i;
  end

  // Hold FSM looks at the next level so a release landing on a terminal
  // tick suppresses long/repeat in that same cycle.
  always_comb begin
    st_d   = st_q;
    hold_d = hold_q;
    long_d = 1'b0;
    rep_d  = 1'b0;
    case (st_q)
      IDLE: begin
        if (lvl_d) begin
          st_d   = PRESSED;
          hold_d = '0;
        end
      end
      PRESSED: begin
        if (!lvl_d) begin
          st_d = IDLE;
        end else if (tick_i) begin
          if (hold_q == HW'(LONG_TICKS - 1)) begin
            long_d = 1'b1;
            hold_d = '0;
            st_d   = HELD;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      HELD: begin
        if (!lvl_d) begin
          st_d = IDLE;
        end else if (tick_i) begin
          if (hold_q == HW'(REP_TICKS - 1)) begin
            rep_d  = REP_EN;
            hold_d = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // Channel state; reset drops everything without emitting a pulse.
  always_ff @(posedge clk or negedge reset_p) begin
    if (!reset_p) begin
      deb_q   <= '0;
      lvl_q   <= 1'b0;
      pedge_q <= 1'b0;
      nedge_q <= 1'b0;
      st_q    <= IDLE;
      hold_q  <= '0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      deb_q   <= deb_d;
      lvl_q   <= lvl_d;
      pedge_q <= pedge_d;
      nedge_q <= nedge_d;
      st_q    <= st_d;
      hold_q  <= hold_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
    end
  end

  assign lvl_o   = lvl_q;
  assign pedge_o = pedge_q;
  assign nedge_o = nedge_q;
  assign long_o  = long_q;
  assign rep_o   = rep_q;
endmodule

module btn_conditioner #(
  parameter int N_BTN      = 4,
  parameter int TICK_CYC   = 100000,
  parameter int DEB_TICKS  = 10,
  parameter int LONG_TICKS = 1000,
  parameter int REP_TICKS  = 200,
  parameter bit REP_EN     = 1'b1
) (
  input logic              clk,
  input logic              reset_p,
  btn_conditioner_if.slave bus
);
  localparam int PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

  logic [PW-1:0]    pre_q, pre_d;
  logic             tick;
  logic [N_BTN-1:0] s1_q, s2_q;
  logic [N_BTN-1:0] lvl, pedge, nedge, lng, rep;

  assign tick  = (pre_q == PW'(TICK_CYC - 1));
  assign pre_d = tick ? '0 : pre_q + PW'(1);

  // Free-running tick prescaler and two-flop pin synchroniser.
  always_ff @(posedge clk or negedge reset_p) begin
    if (!reset_p) begin
      pre_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
    end else begin
      pre_q <= pre_d;
      s1_q  <= bus.btn_raw;
      s2_q  <= s1_q;
    end
  end

  btn_chan #(
    .DEB_TICKS (DEB_TICKS),
    .LONG_TICKS(LONG_TICKS),
    .REP_TICKS (REP_TICKS),
    .REP_EN    (REP_EN)
  ) u_chan [N_BTN-1:0] (
    .clk    (clk),
    .reset_p(reset_p),
    .tick_i (tick),
    .sync_i (s2_q),
    .lvl_o  (lvl),
    .pedge_o(pedge),
    .nedge_o(nedge),
    .long_o (lng),
    .rep_o  (rep)
  );

  assign bus.btn_lvl   = lvl;
  assign bus.btn_pedge = pedge;
  assign bus.btn_nedge = nedge;
  assign bus.long_p    = lng;
  assign bus.rep_p     = rep;
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with a short tick (4 clk), a 3-tick
// debounce, 10-tick long press and 4-tick repeat. A second instance with
// repeat disabled sees the same pins. Pulses are counted per segment as one
// nibble per button; segments are multiples of 4 cycles so the tick phase
// stays fixed relative to each pin change.
module tb_btn_conditioner;
  logic clk = 1'b0;
  logic reset_p;
  always #5 clk = ~clk;

  btn_conditioner_if #(.N_BTN(4)) a_if ();
  btn_conditioner_if #(.N_BTN(4)) b_if ();
  assign b_if.btn_raw = a_if.btn_raw;

  btn_conditioner #(.N_BTN(4), .TICK_CYC(4), .DEB_TICKS(3), .LONG_TICKS(10),
                    .REP_TICKS(4), .REP_EN(1'b1))
    dut (.clk(clk), .reset_p(reset_p), .bus(a_if.slave));

  btn_conditioner #(.N_BTN(4), .TICK_CYC(4), .DEB_TICKS(3), .LONG_TICKS(10),
                    .REP_TICKS(4), .REP_EN(1'b0))
    dut_norep (.clk(clk), .reset_p(reset_p), .bus(b_if.slave));

  typedef struct {
    logic [3:0]  raw;
    int          cyc;
    logic [15:0] pe, ne, lp, rp;  // expected pulse counts, nibble per button
    logic [3:0]  lvl;             // expected level at segment end
  } vec_t;

  int checks = 0, failures = 0;
  logic [15:0] pe_c, ne_c, lp_c, rp_c, pe_c2, ne_c2, lp_c2, rp_c2;
  int seg_j, pe_t, lp2_t, excl_bad;
  logic [3:0] pe_v;
  int rep2_t[$];
  vec_t tbl[9];

  function automatic vec_t mk(logic [3:0] raw, int cyc, logic [15:0] pe,
                              logic [15:0] ne, logic [15:0] lp, logic [15:0] rp,
                              logic [3:0] lvl);
    vec_t v;
    v.raw = raw; v.cyc = cyc; v.pe = pe; v.ne = ne; v.lp = lp; v.rp = rp; v.lvl = lvl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic clr();
    pe_c = '0; ne_c = '0; lp_c = '0; rp_c = '0;
    pe_c2 = '0; ne_c2 = '0; lp_c2 = '0; rp_c2 = '0;
    seg_j = 0; pe_t = -1; pe_v = '0; lp2_t = -1;
    rep2_t.delete();
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      seg_j++;
      for (int b = 0; b < 4; b++) begin
        if (a_if.btn_pedge[b]) pe_c[4*b +: 4] = pe_c[4*b +: 4] + 4'd1;
        if (a_if.btn_nedge[b]) ne_c[4*b +: 4] = ne_c[4*b +: 4] + 4'd1;
        if (a_if.long_p[b])    lp_c[4*b +: 4] = lp_c[4*b +: 4] + 4'd1;
        if (a_if.rep_p[b])     rp_c[4*b +: 4] = rp_c[4*b +: 4] + 4'd1;
        if (b_if.btn_pedge[b]) pe_c2[4*b +: 4] = pe_c2[4*b +: 4] + 4'd1;
        if (b_if.btn_nedge[b]) ne_c2[4*b +: 4] = ne_c2[4*b +: 4] + 4'd1;
        if (b_if.long_p[b])    lp_c2[4*b +: 4] = lp_c2[4*b +: 4] + 4'd1;
        if (b_if.rep_p[b])     rp_c2[4*b +: 4] = rp_c2[4*b +: 4] + 4'd1;
      end
      if (a_if.btn_pedge != 4'h0 && pe_t < 0) begin
        pe_t = seg_j;
        pe_v = a_if.btn_pedge;
      end
      if (a_if.long_p[2]) lp2_t = seg_j;
      if (a_if.rep_p[2])  rep2_t.push_back(seg_j);
      if (((a_if.btn_pedge & a_if.long_p) | (a_if.long_p & a_if.rep_p) |
           (b_if.btn_pedge & b_if.long_p) | (b_if.long_p & b_if.rep_p)) != 4'h0)
        excl_bad++;
    end
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    logic [3:0] expv;
    int prev;
    bit ok;
    clr();
    a_if.btn_raw = v.raw;
    step(v.cyc);
    chk({tag, ".pe"}, pe_c, v.pe);
    chk({tag, ".ne"}, ne_c, v.ne);
    chk({tag, ".long"}, lp_c, v.lp);
    chk({tag, ".rep"}, rp_c, v.rp);
    chk({tag, ".lvl"}, a_if.btn_lvl, v.lvl);
    chk({tag, ".norep_pe"}, pe_c2, v.pe);
    chk({tag, ".norep_ne"}, ne_c2, v.ne);
    chk({tag, ".norep_long"}, lp_c2, v.lp);
    chk({tag, ".norep_rep"}, rp_c2, 16'h0);
    chk({tag, ".norep_lvl"}, b_if.btn_lvl, v.lvl);
    if (v.pe != 16'h0) begin
      for (int b = 0; b < 4; b++) expv[b] = |v.pe[4*b +: 4];
      chk({tag, ".pe_same_cycle"}, pe_v, expv);
      chk({tag, ".pe_latency_10_14"}, (pe_t >= 10 && pe_t <= 14), 1);
    end
    if (v.lp[11:8] != 4'h0) begin
      chk({tag, ".long_after_pe"}, lp2_t - pe_t, 40);
      ok = 1'b1;
      prev = lp2_t;
      foreach (rep2_t[k]) begin
        if (rep2_t[k] - prev != 16) ok = 1'b0;
        prev = rep2_t[k];
      end
      chk({tag, ".rep_period16"}, ok, 1);
    end
  endtask

  initial begin
    tbl[0] = mk(4'h0, 20,  16'h0000, 16'h0010, 16'h0000, 16'h0000, 4'h0); // release btn1
    tbl[1] = mk(4'h4, 152, 16'h0100, 16'h0000, 16'h0100, 16'h0600, 4'h4); // long hold btn2
    tbl[2] = mk(4'h0, 20,  16'h0000, 16'h0100, 16'h0000, 16'h0000, 4'h0); // release on rep tick
    tbl[3] = mk(4'h8, 32,  16'h1000, 16'h0000, 16'h0000, 16'h0000, 4'h8); // short press btn3
    tbl[4] = mk(4'h0, 24,  16'h0000, 16'h1000, 16'h0000, 16'h0000, 4'h0);
    tbl[5] = mk(4'h9, 20,  16'h1001, 16'h0000, 16'h0000, 16'h0000, 4'h9); // simultaneous 0+3
    tbl[6] = mk(4'h0, 20,  16'h0000, 16'h1001, 16'h0000, 16'h0000, 4'h0);
    tbl[7] = mk(4'h2, 8,   16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'h0); // 2-tick glitch
    tbl[8] = mk(4'h0, 20,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'h0);

    excl_bad = 0;
    reset_p = 1'b0;
    a_if.btn_raw = 4'hF;
    clr();
    step(5);
    chk("rst.outs", {a_if.btn_lvl, a_if.btn_pedge, a_if.btn_nedge, a_if.long_p, a_if.rep_p}, 0);
    chk("rst.outs_norep", {b_if.btn_lvl, b_if.btn_pedge, b_if.btn_nedge, b_if.long_p, b_if.rep_p}, 0);

    // Release reset with btn0 still held: it must debounce from scratch.
    a_if.btn_raw = 4'h1;
    reset_p = 1'b1;
    clr();
    step(20);
    chk("rst_rel.pe", pe_c, 16'h0001);
    chk("rst_rel.pe_latency_10_14", (pe_t >= 10 && pe_t <= 14), 1);
    chk("rst_rel.lvl", a_if.btn_lvl, 4'h1);
    apply_vec(mk(4'h0, 20, 16'h0, 16'h0001, 16'h0, 16'h0, 4'h0), "rel0");

    // Bounce btn1 every 5 cycles: never stable for a full window.
    clr();
    for (int k = 0; k < 12; k++) begin
      a_if.btn_raw = (k % 2 == 0) ? 4'h2 : 4'h0;
      step(5);
    end
    chk("bounce.no_pulse", pe_c | ne_c, 16'h0);
    chk("bounce.lvl", a_if.btn_lvl, 4'h0);
    apply_vec(mk(4'h2, 20, 16'h0010, 16'h0, 16'h0, 16'h0, 4'h2), "bounce_settle");

    for (int i = 0; i < 9; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset 20 cycles into HELD (HELD starts 52 cycles after the press).
    clr();
    a_if.btn_raw = 4'h4;
    step(72);
    chk("midhold.long", lp_c, 16'h0100);
    chk("midhold.rep", rp_c, 16'h0100);
    reset_p = 1'b0;
    #1;
    chk("midhold.rst_outs", {a_if.btn_lvl, a_if.btn_pedge, a_if.btn_nedge, a_if.long_p, a_if.rep_p}, 0);
    chk("midhold.rst_outs_norep", {b_if.btn_lvl, b_if.btn_pedge, b_if.btn_nedge, b_if.long_p, b_if.rep_p}, 0);
    clr();
    step(8);
    chk("midhold.no_nedge", pe_c | ne_c | lp_c | rp_c | pe_c2 | ne_c2 | lp_c2 | rp_c2, 16'h0);
    reset_p = 1'b1;
    apply_vec(mk(4'h4, 20, 16'h0100, 16'h0, 16'h0, 16'h0, 4'h4), "midhold.repress");
    apply_vec(mk(4'h0, 20, 16'h0, 16'h0100, 16'h0, 16'h0, 4'h0), "midhold.release");

    chk("pulse_exclusive", excl_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
